// File: rtl/weight_loader.sv
// weight_loader: streams host weight/bias words onto the shared node bus,
// pulsing the one-hot shift enable of the node currently being filled.
// Ports:
//   clk, rst       rising-edge clock, async active-low reset
//   start, abort   begin a load pass (IDLE) / cancel it (LOAD)
//   in_valid/in_ready/in_data   host word handshake
//   we, bus_d, bus_oe  one-cycle node write, one clock after accept
//   busy, done, node_idx  pass status
module weight_loader #(
    parameter int n   = 16,
    parameter int sx  = 2,
    parameter int sl1 = 2,
    parameter int sl2 = 2,
    parameter int sl  = 1,
    parameter int nd  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*n-1:0]        in_data,
    output logic [nd-1:0]         we,
    output logic [2*n-1:0]        bus_d,
    output logic                  bus_oe,
    output logic                  busy,
    output logic                  done,
    output logic [$clog2(nd)-1:0] node_idx
);

    localparam int NW = $clog2(nd);
    localparam int CW = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] fanin;
    logic          acc;
    logic          last_word;
    logic          last_node;
    logic [nd-1:0] onehot;

    // Words per node is fan-in + 1, so the counter's last value is the fan-in.
    always_comb begin
        fanin = CW'(sl2);
        if (node_idx < NW'(sl1))
            fanin = CW'(sx);
        else if (node_idx < NW'(sl1 + sl2))
            fanin = CW'(sl1);
    end

    // An aborted cycle never counts as an accepted word.
    assign acc       = (state == LOAD) && in_valid && !abort;
    assign last_word = (wcnt == fanin);
    assign last_node = (node_idx == NW'(nd - 1));
    // Node 0 owns the MSB of we.
    assign onehot    = {1'b1, {(nd-1){1'b0}}} >> node_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: begin
                if (abort)
                    state_nx = IDLE;
                else if (acc && last_word && last_node)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD);
        busy     = (state == LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we       <= '0;
            bus_d    <= '0;
            bus_oe   <= 1'b0;
            done     <= 1'b0;
            wcnt     <= '0;
            node_idx <= '0;
        end else begin
            we     <= acc ? onehot : '0;
            bus_d  <= acc ? in_data : '0;
            bus_oe <= acc;
            // Registered so the pulse lands one cycle after the final write.
            done   <= (state == DONE);
            if (state == IDLE && start) begin
                wcnt     <= '0;
                node_idx <= '0;
            end else if (acc) begin
                if (last_word) begin
                    wcnt <= '0;
                    if (!last_node)
                        node_idx <= node_idx + 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed and random load passes for weight_loader,
// checked cycle by cycle against a word-index reference model.
module tb_weight_loader;

    localparam int N     = 16;
    localparam int SX    = 2;
    localparam int SL1   = 2;
    localparam int SL2   = 2;
    localparam int SL    = 1;
    localparam int ND    = 5;
    localparam int TOTAL = SL1*(SX+1) + SL2*(SL1+1) + SL*(SL2+1);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2*N-1:0]  in_data = '0;
    logic [ND-1:0]   we;
    logic [2*N-1:0]  bus_d;
    logic            bus_oe;
    logic            busy;
    logic            done;
    logic [2:0]      node_idx;

    int total = 0;
    int bad = 0;
    int mphase = 0;
    int k = 0;
    int pass_wr = 0;
    int pass_done = 0;

    weight_loader #(
        .n(N), .sx(SX), .sl1(SL1), .sl2(SL2), .sl(SL), .nd(ND)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .we(we), .bus_d(bus_d), .bus_oe(bus_oe), .busy(busy),
        .done(done), .node_idx(node_idx)
    );

    always #5 clk = ~clk;

    function automatic int wpn(int nd_i);
        if (nd_i < SL1) return SX + 1;
        if (nd_i < SL1 + SL2) return SL1 + 1;
        return SL2 + 1;
    endfunction

    function automatic int node_of(int kk);
        int r = kk;
        for (int i = 0; i < ND; i++) begin
            if (r < wpn(i)) return i;
            r -= wpn(i);
        end
        return ND - 1;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(logic s, logic a, logic v, logic [2*N-1:0] d);
        logic [ND-1:0]  e_we;
        logic [2*N-1:0] e_d;
        logic           e_oe;
        logic           e_done;
        int             nph;
        start = s; abort = a; in_valid = v; in_data = d;
        e_we = '0; e_d = '0; e_oe = 1'b0;
        e_done = (mphase == 2);
        nph = mphase;
        case (mphase)
            0: if (s) begin nph = 1; k = 0; end
            1: begin
                if (a) nph = 0;
                else if (v) begin
                    e_we[ND-1-node_of(k)] = 1'b1;
                    e_d = d; e_oe = 1'b1;
                    k++;
                    if (k == TOTAL) nph = 2;
                end
            end
            default: nph = 0;
        endcase
        @(posedge clk); #1;
        mphase = nph;
        chk("we", 64'(we), 64'(e_we));
        chk("bus_d", 64'(bus_d), 64'(e_d));
        chk("bus_oe", 64'(bus_oe), 64'(e_oe));
        chk("done", 64'(done), 64'(e_done));
        chk("busy", 64'(busy), 64'(nph == 1));
        chk("in_ready", 64'(in_ready), 64'(nph == 1));
        chk("we_onehot", 64'($countones(we) <= 1), 64'(1));
        if (nph == 1) chk("node_idx", 64'(node_idx), 64'(node_of(k)));
        if (we != '0) pass_wr++;
        if (done) pass_done++;
    endtask

    task automatic end_pass(int wr, int dn);
        cyc(0, 0, 0, 32'(0));
        cyc(0, 0, 0, 32'(0));
        chk("pass_writes", 64'(pass_wr), 64'(wr));
        chk("pass_done", 64'(pass_done), 64'(dn));
        pass_wr = 0;
        pass_done = 0;
    endtask

    initial begin
        #2;
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_oe", 64'(bus_oe), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_node", 64'(node_idx), 64'(0));
        @(negedge clk); rst = 1'b1;
        cyc(0, 0, 1, 32'(7));

        // Full back-to-back pass, words 1..15.
        cyc(1, 0, 0, 32'(0));
        for (int w = 1; w <= TOTAL; w++) cyc(0, 0, 1, 32'(w));
        end_pass(TOTAL, 1);

        // Stalls after words 2 and 9; start+abort together in IDLE.
        cyc(1, 1, 0, 32'(0));
        for (int w = 1; w <= TOTAL; w++) begin
            cyc(0, 0, 1, 32'(w));
            if (w == 2 || w == 9)
                for (int g = 0; g < 3; g++) cyc(0, 0, 0, $urandom);
        end
        end_pass(TOTAL, 1);

        // Abort on word 5, then a fresh full pass.
        cyc(1, 0, 0, 32'(0));
        for (int w = 1; w <= 4; w++) cyc(0, 0, 1, 32'(w));
        cyc(0, 1, 1, 32'(5));
        end_pass(4, 0);
        cyc(1, 0, 0, 32'(0));
        for (int w = 1; w <= TOTAL; w++) cyc(0, 0, 1, $urandom);
        end_pass(TOTAL, 1);

        // Async reset after word 7.
        cyc(1, 0, 0, 32'(0));
        for (int w = 1; w <= 7; w++) cyc(0, 0, 1, 32'(w));
        #1 rst = 1'b0;
        #1;
        chk("arst_we", 64'(we), 64'(0));
        chk("arst_oe", 64'(bus_oe), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        mphase = 0; k = 0;
        @(negedge clk); rst = 1'b1;
        pass_wr = 0; pass_done = 0;
        cyc(0, 0, 1, 32'(8));
        cyc(0, 0, 1, 32'(9));
        end_pass(0, 0);

        // start asserted during LOAD and on the DONE cycle.
        cyc(1, 0, 0, 32'(0));
        for (int w = 1; w <= TOTAL; w++) cyc(w % 4 == 0, 0, 1, 32'(w));
        cyc(1, 0, 0, 32'(0));
        cyc(0, 0, 0, 32'(0));
        end_pass(TOTAL, 1);

        // Random-valid pass with random data, bounded.
        cyc(1, 0, 0, 32'(0));
        for (int i = 0; i < 300 && mphase == 1; i++)
            cyc(0, 0, 1'($urandom), $urandom);
        end_pass(TOTAL, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
